// File: rtl/sap_pkg.sv
// ---------------------------------------------------------------------------
// sap_pkg -- shared definitions for the SAP computer blocks.
//
// Purpose : holds the program-loader FSM state type, the program memory depth
//           and a small byte-checksum helper. Other blocks pull these in with
//           import sap_pkg::*.
// Ports   : none (package).
// Config  : the checksum helper is only used when PROG_LOADER_CHECKSUM_EN is
//           defined for prog_loader.
// ---------------------------------------------------------------------------
package sap_pkg;

  // Number of bytes in the SAP program memory (one full load).
  localparam int SAP_MEM_DEPTH = 16;

  // Loader states. CHECK is only reachable when checksum checking is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Running mod-256 checksum: the carry out of bit 7 is simply dropped.
  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader -- streams a program image into the SAP program memory.
//
// Purpose : after a start request, accepts DEPTH bytes over a valid/ready
//           stream and writes them to consecutive memory addresses while the
//           CPU is held in reset. A one-cycle done pulse marks completion and
//           releases the CPU in the same cycle.
//
// Ports   :
//   clk        in   system clock, all state changes on its rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a load (only honoured while idle)
//   in_valid   in   source presents a program byte
//   in_data    in   program byte [7:0]
//   in_ready   out  loader accepts a byte this cycle (state decode only)
//   mem_we     out  memory write strobe, one cycle after each accepted byte
//   mem_addr   out  memory write address [ADDR_W-1:0]
//   mem_wdata  out  memory write data [7:0]
//   cpu_hold   out  holds the CPU in reset during a load
//   err        out  sticky checksum failure (only with PROG_LOADER_CHECKSUM_EN)
//   done       out  one-cycle completion pulse
//
// Config  : define PROG_LOADER_CHECKSUM_EN to add the CHECK state. The loader
//           then sums the DEPTH program bytes mod 256, accepts one extra
//           checksum byte and flags err when it does not match. Without the
//           macro there is no CHECK state, no accumulator and no err port.
//
// Parameters: DEPTH bytes per program, ADDR_W address bits; DEPTH must equal
//           2**ADDR_W so that the address counter wraps to 0 after the last
//           byte on its own.
// ---------------------------------------------------------------------------
module prog_loader
  import sap_pkg::*;
#(
  parameter int DEPTH  = SAP_MEM_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
`ifdef PROG_LOADER_CHECKSUM_EN
  output logic              err,
`endif
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] count;
  logic              accept;
  logic              load_accept;
  logic              last_byte;
  logic              start_load;

  // Handshake and status outputs are pure decodes of the state register, so
  // in_ready never depends combinationally on in_valid and every one of them
  // drops the moment reset forces the state back to IDLE.
  assign in_ready    = (state == LOAD) || (state == CHECK);
  assign cpu_hold    = (state == LOAD) || (state == CHECK);
  assign done        = (state == DONE);

  assign accept      = in_valid && in_ready;
  assign load_accept = accept && (state == LOAD);
  assign last_byte   = load_accept && (count == LAST_ADDR);
  assign start_load  = start && (state == IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A start seen in LOAD, CHECK or DONE has no effect, so
  // a start coinciding with the done pulse does not restart the load.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (last_byte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address counter and memory write port. Each byte accepted in LOAD is
  // registered into a single-cycle write; the strobe falls back to 0 on every
  // other cycle, so the checksum byte in CHECK never reaches memory. The
  // counter is ADDR_W bits wide and wraps to 0 after the last address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_load) begin
        count <= '0;
      end else if (load_accept) begin
        mem_we    <= 1'b1;
        mem_addr  <= count;
        mem_wdata <= in_data;
        count     <= count + 1'b1;
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  // Checksum accumulator and sticky error flag. Both clear when a new load
  // starts; err is then only re-evaluated by the byte accepted in CHECK,
  // compared against the sum of all DEPTH program bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (start_load) begin
        sum <= '0;
        err <= 1'b0;
      end else if (load_accept) begin
        sum <= sum8(sum, in_data);
      end else if (accept && (state == CHECK)) begin
        err <= (in_data != sum);
      end
    end
  end
`endif

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of memory bytes loaded per program.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning the memory address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit, a request to begin a load sequence.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning the source is presenting a program byte.
REQ-007 SHALL have port in_data, input, 8 bits, the program byte.
REQ-008 SHALL have port in_ready, output, 1 bit, meaning the loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we, output, 1 bit, the memory write strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W bits, the memory write address.
REQ-011 SHALL have port mem_wdata, output, 8 bits, the memory write data.
REQ-012 SHALL have port cpu_hold, output, 1 bit, which holds the CPU in reset while loading.
REQ-013 SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-014 SHALL have port err, output, 1 bit, a sticky checksum-failure flag; it is present only when checksum checking is compiled in.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, CHECK and DONE.
REQ-016 SHALL leave IDLE for LOAD, clear the byte counter and set cpu_hold when start=1 is sampled in IDLE.
REQ-017 SHALL drive in_ready=1 only in LOAD and CHECK, as a registered-state decode with no combinational path from in_valid.
REQ-018 SHALL accept a byte exactly on a cycle where in_valid=1 and in_ready=1; in_data SHALL be ignored on all other cycles.
REQ-019 SHALL, on each acceptance in LOAD, register mem_we=1, mem_addr=counter and mem_wdata=in_data for exactly the next cycle, giving write latency 1.
REQ-020 SHALL increment the counter per accepted byte; acceptance at counter=DEPTH-1 SHALL wrap the counter to 0 and move the FSM to CHECK (macro defined) or DONE (macro undefined).
REQ-021 SHALL remain in LOAD indefinitely while in_valid=0, with no timeout.
REQ-022 SHALL leave DONE for IDLE after exactly one cycle, with done=1 and cpu_hold deasserted in that same DONE cycle.
REQ-023 SHALL ignore start outside IDLE, including a start coinciding with the DONE cycle.
REQ-024 SHALL keep mem_we=0 in every cycle other than the one following an accepted LOAD byte; no write SHALL ever occur in CHECK.

Reset
REQ-025 SHALL, on rst=1, immediately set state=IDLE, counter=0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0 and err=0.
REQ-026 SHALL, when reset is asserted mid-load, discard the remaining bytes without further writes; a new start is required afterwards.

Configuration
REQ-027 SHALL, with PROG_LOADER_CHECKSUM_EN defined, accumulate an 8-bit mod-256 sum of the DEPTH accepted bytes.
REQ-028 SHALL, with that macro defined, accept one byte in CHECK and set err=1 if the byte differs from the sum; err SHALL clear only on the next start or on reset.
REQ-029 SHALL, with that macro defined, then enter DONE regardless of the check result.
REQ-030 SHALL, without that macro, omit the CHECK state, the sum accumulator and the err port.

Structure
REQ-031 SHALL take the FSM state typedef (IDLE/LOAD/CHECK/DONE) and the SAP_MEM_DEPTH=16 constant from the shared package sap_pkg.
REQ-032 SHALL be a single module with no sub-module; the counter and accumulator are too small to warrant one.

Verification
REQ-033 SHALL cover: start, then 16 bytes 0x00..0x0F back-to-back -> 16 writes with addr n, data n on the cycles after acceptance; done on cycle after last; cpu_hold low at done.
REQ-034 SHALL cover: in_valid toggled 1/0 every cycle -> 16 writes only on accepted cycles, mem_we never high twice for one byte.
REQ-035 SHALL cover: rst asserted after byte 7 -> mem_we=0 and cpu_hold=0 immediately, no further writes, and a later start reloads from addr 0.
REQ-036 SHALL cover: start pulsed during LOAD and on the DONE cycle -> no restart, counter continues, FSM ends in IDLE.
REQ-037 SHALL cover, with PROG_LOADER_CHECKSUM_EN: 16 bytes of 0x11 then 0x10 -> err=0; the same data then 0x11 -> err=1, done still pulses, err cleared by the next start.
